// File: rtl/cs_flow_if.sv
// Stage start/done handshake bundle between cs_flow (master) and the five
// stage engines (slave): the master raises fs_*, the engine answers on fd_*.
interface cs_flow_if;
  logic fs_adc_check;
  logic fd_adc_check;
  logic fs_adc_conf;
  logic fd_adc_conf;
  logic fs_adc_read;
  logic fd_adc_read;
  logic fs_adc_fifo;
  logic fd_adc_fifo;
  logic fs_udp_tx;
  logic fd_udp_tx;

  modport master (
    output fs_adc_check, fs_adc_conf, fs_adc_read, fs_adc_fifo, fs_udp_tx,
    input  fd_adc_check, fd_adc_conf, fd_adc_read, fd_adc_fifo, fd_udp_tx
  );

  modport slave (
    input  fs_adc_check, fs_adc_conf, fs_adc_read, fs_adc_fifo, fs_udp_tx,
    output fd_adc_check, fd_adc_conf, fd_adc_read, fd_adc_fifo, fd_udp_tx
  );
endinterface

// File: rtl/cs_flow.sv
// ADC capture / UDP transmit flow sequencer with registered stage starts.
// Optional stage watchdog and ERR state are enabled by `define CS_FLOW_TIMEOUT_EN.
module cs_flow #(
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fs_adc,
  input  logic        conf_req,
  input  logic        err_clr,
  cs_flow_if.master   stg,
  output logic        busy,
  output logic        err,
  output logic [2:0]  err_code,
  output logic [7:0]  ovr_cnt
);

  typedef enum logic [2:0] {
    S_INIT_CHECK,
    S_INIT_CONF,
    S_IDLE,
    S_CONF,
    S_READ,
    S_FIFO,
    S_TX,
    S_ERR
  } state_t;

  state_t      state_q, state_d;
  logic        pending_q, pending_d;
  logic [7:0]  ovr_q, ovr_d;
  logic [2:0]  err_code_q, err_code_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;
  logic        fs_check_q, fs_check_d;
  logic        fs_conf_q, fs_conf_d;
  logic        fs_read_q, fs_read_d;
  logic        fs_fifo_q, fs_fifo_d;
  logic        fs_tx_q, fs_tx_d;

  logic        in_stage;
  logic        stage_fd;
  logic [2:0]  stage_id;
  logic        drop_adc;

`ifdef CS_FLOW_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = TIMEOUT - 16'd1;
  logic [15:0] timer_q, timer_d;
`else
  logic [16:0] unused_cfg;
  assign unused_cfg = {err_clr, TIMEOUT};
`endif

  // Only the done flag of the stage currently being driven is looked at.
  always_comb begin
    in_stage = 1'b1;
    stage_fd = 1'b0;
    stage_id = 3'd0;
    unique case (state_q)
      S_INIT_CHECK: begin stage_fd = stg.fd_adc_check; stage_id = 3'd1; end
      S_INIT_CONF,
      S_CONF:       begin stage_fd = stg.fd_adc_conf;  stage_id = 3'd2; end
      S_READ:       begin stage_fd = stg.fd_adc_read;  stage_id = 3'd3; end
      S_FIFO:       begin stage_fd = stg.fd_adc_fifo;  stage_id = 3'd4; end
      S_TX:         begin stage_fd = stg.fd_udp_tx;    stage_id = 3'd5; end
      default:      in_stage = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    ovr_d      = ovr_q;
    err_code_d = err_code_q;

    unique case (state_q)
      S_INIT_CHECK: if (stage_fd) state_d = S_INIT_CONF;
      S_INIT_CONF:  if (stage_fd) state_d = S_IDLE;
      S_CONF:       if (stage_fd) state_d = S_IDLE;
      S_READ:       if (stage_fd) state_d = S_FIFO;
      S_FIFO:       if (stage_fd) state_d = S_TX;
      S_TX:         if (stage_fd) state_d = S_IDLE;
      S_IDLE: begin
        if (pending_q || conf_req) state_d = S_CONF;
        else if (fs_adc)           state_d = S_READ;
      end
      S_ERR: begin
`ifdef CS_FLOW_TIMEOUT_EN
        if (err_clr) begin
          state_d    = S_INIT_CHECK;
          err_code_d = 3'd0;
        end
`endif
      end
      default: state_d = S_INIT_CHECK;
    endcase

`ifdef CS_FLOW_TIMEOUT_EN
    // A done flag on the expiry cycle still completes the stage.
    timer_d = timer_q;
    if (in_stage && !stage_fd && timer_q == TIMEOUT_LAST) begin
      state_d    = S_ERR;
      err_code_d = stage_id;
    end
    if (state_d != state_q) timer_d = 16'd0;
    else if (in_stage)      timer_d = timer_q + 16'd1;
`endif

    if (conf_req && state_q != S_IDLE) pending_d = 1'b1;
    if (state_q == S_IDLE && state_d == S_CONF) pending_d = 1'b0;

    drop_adc = fs_adc && (state_q != S_IDLE || pending_q || conf_req);
    if (drop_adc && ovr_q != 8'hFF) ovr_d = ovr_q + 8'd1;

    fs_check_d = (state_d == S_INIT_CHECK);
    fs_conf_d  = (state_d == S_INIT_CONF) || (state_d == S_CONF);
    fs_read_d  = (state_d == S_READ);
    fs_fifo_d  = (state_d == S_FIFO);
    fs_tx_d    = (state_d == S_TX);
    busy_d     = (state_d != S_IDLE);
`ifdef CS_FLOW_TIMEOUT_EN
    err_d      = (state_d == S_ERR);
`else
    err_d      = 1'b0;
    err_code_d = 3'd0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_INIT_CHECK;
      pending_q  <= 1'b0;
      ovr_q      <= 8'd0;
      err_code_q <= 3'd0;
      err_q      <= 1'b0;
      busy_q     <= 1'b1;
      fs_check_q <= 1'b1;
      fs_conf_q  <= 1'b0;
      fs_read_q  <= 1'b0;
      fs_fifo_q  <= 1'b0;
      fs_tx_q    <= 1'b0;
`ifdef CS_FLOW_TIMEOUT_EN
      timer_q    <= 16'd0;
`endif
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      ovr_q      <= ovr_d;
      err_code_q <= err_code_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      fs_check_q <= fs_check_d;
      fs_conf_q  <= fs_conf_d;
      fs_read_q  <= fs_read_d;
      fs_fifo_q  <= fs_fifo_d;
      fs_tx_q    <= fs_tx_d;
`ifdef CS_FLOW_TIMEOUT_EN
      timer_q    <= timer_d;
`endif
    end
  end

  assign stg.fs_adc_check = fs_check_q;
  assign stg.fs_adc_conf  = fs_conf_q;
  assign stg.fs_adc_read  = fs_read_q;
  assign stg.fs_adc_fifo  = fs_fifo_q;
  assign stg.fs_udp_tx    = fs_tx_q;
  assign busy             = busy_q;
  assign err              = err_q;
  assign err_code         = err_code_q;
  assign ovr_cnt          = ovr_q;

endmodule

// File: tb/tb_cs_flow.sv
// Directed self-checking bench for cs_flow; inputs change and outputs are
// sampled on the falling clock edge.
module tb_cs_flow;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fs_adc = 1'b0;
  logic       conf_req = 1'b0;
  logic       err_clr = 1'b0;
  logic       busy, err;
  logic [2:0] err_code;
  logic [7:0] ovr_cnt;
  int         checks = 0;
  int         failures = 0;

  cs_flow_if stg ();

  cs_flow #(.TIMEOUT(16'd16)) dut (
    .clk      (clk),
    .rst      (rst),
    .fs_adc   (fs_adc),
    .conf_req (conf_req),
    .err_clr  (err_clr),
    .stg      (stg),
    .busy     (busy),
    .err      (err),
    .err_code (err_code),
    .ovr_cnt  (ovr_cnt)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        failures++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  // One-cycle pulse on the control inputs (0=fs_adc 1=conf_req 2=err_clr)
  task automatic applyStimulus(input logic a, input logic c, input logic e);
    fs_adc = a; conf_req = c; err_clr = e;
    cyc(1);
    fs_adc = 1'b0; conf_req = 1'b0; err_clr = 1'b0;
  endtask

  // One-cycle pulse on a done flag (0 check,1 conf,2 read,3 fifo,4 tx)
  task automatic pulseFd(input int which);
    case (which)
      0: stg.fd_adc_check = 1'b1;
      1: stg.fd_adc_conf  = 1'b1;
      2: stg.fd_adc_read  = 1'b1;
      3: stg.fd_adc_fifo  = 1'b1;
      default: stg.fd_udp_tx = 1'b1;
    endcase
    cyc(1);
    stg.fd_adc_check = 1'b0; stg.fd_adc_conf = 1'b0; stg.fd_adc_read = 1'b0;
    stg.fd_adc_fifo  = 1'b0; stg.fd_udp_tx   = 1'b0;
  endtask

  function automatic logic [4:0] fsVec();
    return {stg.fs_adc_check, stg.fs_adc_conf, stg.fs_adc_read, stg.fs_adc_fifo, stg.fs_udp_tx};
  endfunction

  task automatic doInit();
    rst = 1'b0;
    cyc(1);
    pulseFd(0);
    pulseFd(1);
  endtask

  initial begin
    stg.fd_adc_check = 1'b0; stg.fd_adc_conf = 1'b0; stg.fd_adc_read = 1'b0;
    stg.fd_adc_fifo  = 1'b0; stg.fd_udp_tx   = 1'b0;

    cyc(2);
    rst = 1'b0;
    checkOutput("rst_fs", {3'b0, fsVec()}, 8'b10000);
    checkOutput("rst_busy", {7'b0, busy}, 8'd1);
    checkOutput("rst_err", {7'b0, err}, 8'd0);
    checkOutput("rst_err_code", {5'b0, err_code}, 8'd0);
    checkOutput("rst_ovr", ovr_cnt, 8'd0);

    cyc(2);
    checkOutput("check_wait", {3'b0, fsVec()}, 8'b10000);
    pulseFd(0);
    checkOutput("init_conf_fs", {3'b0, fsVec()}, 8'b01000);
    pulseFd(2);
    checkOutput("stray_fd_ignored", {3'b0, fsVec()}, 8'b01000);
    pulseFd(1);
    checkOutput("idle_fs", {3'b0, fsVec()}, 8'b00000);
    checkOutput("idle_busy", {7'b0, busy}, 8'd0);

    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("errclr_idle_ignored", {7'b0, busy}, 8'd0);

    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("frame_read", {3'b0, fsVec()}, 8'b00100);
    checkOutput("frame_busy", {7'b0, busy}, 8'd1);
    cyc(1);
    pulseFd(2);
    checkOutput("frame_fifo", {3'b0, fsVec()}, 8'b00010);
    cyc(1);
    pulseFd(3);
    checkOutput("frame_tx", {3'b0, fsVec()}, 8'b00001);
    cyc(1);
    pulseFd(4);
    checkOutput("frame_idle_busy", {7'b0, busy}, 8'd0);
    checkOutput("frame_ovr", ovr_cnt, 8'd0);

    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      cyc(1);
    end
    checkOutput("ovr_saturated", ovr_cnt, 8'd255);
    checkOutput("ovr_still_read", {3'b0, fsVec()}, 8'b00100);
    pulseFd(2);
    pulseFd(3);
    pulseFd(4);
    checkOutput("ovr_no_extra_frame", {7'b0, busy}, 8'd0);
    checkOutput("ovr_hold", ovr_cnt, 8'd255);

    applyStimulus(1'b1, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_fs", {3'b0, fsVec()}, 8'b10000);
    checkOutput("async_rst_ovr", ovr_cnt, 8'd0);
    cyc(1);
    doInit();
    checkOutput("reinit_idle", {7'b0, busy}, 8'd0);

    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("prio_conf_fs", {3'b0, fsVec()}, 8'b01000);
    checkOutput("prio_ovr", ovr_cnt, 8'd1);
    pulseFd(1);
    checkOutput("prio_idle", {7'b0, busy}, 8'd0);

    applyStimulus(1'b1, 1'b0, 1'b0);
    pulseFd(2);
    pulseFd(3);
    checkOutput("pend_tx", {3'b0, fsVec()}, 8'b00001);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("pend_still_tx", {3'b0, fsVec()}, 8'b00001);
    pulseFd(4);
    checkOutput("pend_idle", {7'b0, busy}, 8'd0);
    cyc(1);
    checkOutput("pend_conf_fs", {3'b0, fsVec()}, 8'b01000);
    pulseFd(1);
    checkOutput("pend_done", {7'b0, busy}, 8'd0);
    checkOutput("pend_ovr", ovr_cnt, 8'd1);

`ifdef CS_FLOW_TIMEOUT_EN
    applyStimulus(1'b1, 1'b0, 1'b0);
    pulseFd(2);
    checkOutput("to_fifo", {3'b0, fsVec()}, 8'b00010);
    cyc(15);
    checkOutput("to_fifo_last", {3'b0, fsVec()}, 8'b00010);
    checkOutput("to_no_err_yet", {7'b0, err}, 8'd0);
    cyc(1);
    checkOutput("to_err", {7'b0, err}, 8'd1);
    checkOutput("to_err_code", {5'b0, err_code}, 8'd4);
    checkOutput("to_err_fs", {3'b0, fsVec()}, 8'b00000);
    checkOutput("to_err_busy", {7'b0, busy}, 8'd1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("to_err_ovr", ovr_cnt, 8'd2);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("to_clr_fs", {3'b0, fsVec()}, 8'b10000);
    checkOutput("to_clr_err", {7'b0, err}, 8'd0);
    checkOutput("to_clr_code", {5'b0, err_code}, 8'd0);
    pulseFd(0);
    pulseFd(1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    pulseFd(2);
    cyc(15);
    pulseFd(3);
    checkOutput("to_fd_wins_fs", {3'b0, fsVec()}, 8'b00001);
    checkOutput("to_fd_wins_err", {7'b0, err}, 8'd0);
    pulseFd(4);
    checkOutput("to_final_idle", {7'b0, busy}, 8'd0);
`else
    applyStimulus(1'b1, 1'b0, 1'b0);
    pulseFd(2);
    pulseFd(3);
    cyc(2000);
    checkOutput("noto_tx_held", {3'b0, fsVec()}, 8'b00001);
    checkOutput("noto_err", {7'b0, err}, 8'd0);
    checkOutput("noto_err_code", {5'b0, err_code}, 8'd0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("noto_errclr_ignored", {3'b0, fsVec()}, 8'b00001);
    pulseFd(4);
    checkOutput("noto_idle", {7'b0, busy}, 8'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
